// File: rtl/fifo_reader.sv
`timescale 1ns/1ps
// Purpose : Pulls a burst of burst_len words out of a first-word-fall-through FIFO and presents them on a registered valid/ready stream.
// Latency : start sampled at edge t0 -> fifo_rd in cycle t0+1 -> m_valid in cycle t0+2; one word per cycle sustained.
// Backpress: m_ready=0 with m_valid=1 holds m_data/m_valid and stops FIFO reads; an empty FIFO stalls the burst without losing words.
//
// Ports
//   clk, reset       : clock (rising edge) and asynchronous active-high reset
//   start, burst_len : burst request and length, both sampled only in IDLE
//   fifo_empty       : FIFO empty flag
//   fifo_rdata       : FIFO head word, valid whenever fifo_empty=0
//   fifo_rd          : FIFO pop strobe (combinational), head popped on the next rising edge
//   m_data, m_valid  : registered downstream word and valid
//   m_ready          : downstream ready
//   busy             : high in every state except IDLE
//   done             : one-cycle pulse when the burst has fully drained downstream
//   stall_count      : downstream stall cycle counter, saturating at 16'hFFFF
//
// Build option: define FIFO_READER_STALL_CNT_EN to build the stall counter; without it
// stall_count is tied to zero and no counter exists.

module fifo_reader #(
    parameter int N = 8,    // data word width
    parameter int L = 8     // burst length / counter width
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [L-1:0] burst_len,
    input  logic         fifo_empty,
    input  logic [N-1:0] fifo_rdata,
    output logic         fifo_rd,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         done,
    output logic [15:0]  stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [L-1:0]   remaining;
    logic [L-1:0]   remaining_nxt;

    logic           slot_free;
    logic           rd_en;
    logic           last_rd;
    logic           burst_start;

    // ------------------------------------------------------------------
    // Read qualification
    // ------------------------------------------------------------------
    // The output register can take a new word when it is empty or when its
    // current word is leaving this cycle. Reset gates the pop strobe
    // directly so the FIFO never sees a read while reset is held, even
    // before the state register has been observed as IDLE.
    always_comb begin
        slot_free   = (~m_valid) | m_ready;
        rd_en       = (state == RUN) & (~fifo_empty) & slot_free & (~reset);
        last_rd     = rd_en & (remaining == L'(1));
        burst_start = (state == IDLE) & start;
    end

    assign fifo_rd = rd_en;

    // ------------------------------------------------------------------
    // FSM: state and remaining-word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;

        case (state)
            IDLE: begin
                // A zero-length request completes immediately without
                // touching the FIFO.
                if (start) begin
                    if (burst_len != '0) begin
                        remaining_nxt = burst_len;
                        state_nxt     = RUN;
                    end else begin
                        state_nxt     = DONE;
                    end
                end
            end

            RUN: begin
                if (rd_en) begin
                    remaining_nxt = remaining - L'(1);
                end
                // Popping the final word ends the read phase; the word is
                // still in the output register and must be accepted before
                // the burst is reported complete.
                if (last_rd) begin
                    state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                if (m_valid & m_ready) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // A pop always refills the register. Without a pop, an accepted word
    // empties it; an unaccepted word holds both data and valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (rd_en) begin
            m_data  <= fifo_rdata;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Downstream stall counter
    // ------------------------------------------------------------------
`ifdef FIFO_READER_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Cleared whenever a new request is accepted so each burst reports its
    // own stall cycles; the value persists in IDLE for inspection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (burst_start) begin
            stall_cnt_q <= '0;
        end else if (m_valid & ~m_ready & (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
`timescale 1ns/1ps
// Directed bench for fifo_reader: behavioural FWFT FIFO source, stream monitor,
// and a linear sequence of hand-computed checks.

module tb_fifo_reader;

    localparam int N = 8;
    localparam int L = 8;

`ifdef FIFO_READER_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [L-1:0]  burst_len;
    logic          fifo_empty;
    logic [N-1:0]  fifo_rdata;
    logic          fifo_rd;
    logic [N-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic [15:0]   stall_count;

    fifo_reader #(.N(N), .L(L)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .burst_len   (burst_len),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd     (fifo_rd),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: the initial block writes (mem, wp), the pop process reads (rp).
    logic [N-1:0] mem [0:1023];
    int           wp = 0;
    int           rp = 0;
    logic         pop_now;

    assign fifo_empty = (wp == rp);
    assign fifo_rdata = mem[rp[9:0]];

    always @(posedge clk) begin
        pop_now = fifo_rd;
        #1;
        if (pop_now) rp = rp + 1;
    end

    // Stream monitor, sampled mid-cycle.
    int           n_xfer = 0;
    int           n_rd   = 0;
    int           n_done = 0;
    int           n_busy = 0;
    int           n_viol = 0;
    logic [N-1:0] xlog [0:1023];

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            xlog[n_xfer[9:0]] = m_data;
            n_xfer = n_xfer + 1;
        end
        if (fifo_rd)               n_rd   = n_rd + 1;
        if (done)                  n_done = n_done + 1;
        if (busy)                  n_busy = n_busy + 1;
        if (fifo_rd && fifo_empty) n_viol = n_viol + 1;
    end

    int vectors     = 0;
    int miscompares = 0;
    int x0, r0, d0, b0, v0;
    int bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [N-1:0] w);
        mem[wp[9:0]] = w;
        wp = wp + 1;
    endtask

    task automatic snap();
        x0 = n_xfer; r0 = n_rd; d0 = n_done; b0 = n_busy; v0 = n_viol;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            step();
            i = i + 1;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] e35 [0:3];
    logic [N-1:0] e36 [0:2];
    logic [N-1:0] e37 [0:3];

    initial begin
        e35[0] = 8'h11; e35[1] = 8'h22; e35[2] = 8'h33; e35[3] = 8'h44;
        e36[0] = 8'h5A; e36[1] = 8'h6B; e36[2] = 8'h7C;
        e37[0] = 8'hC1; e37[1] = 8'hC2; e37[2] = 8'hC3; e37[3] = 8'hC4;

        reset     = 1'b1;
        start     = 1'b0;
        burst_len = '0;
        m_ready   = 1'b1;
        for (int k = 0; k < 4; k++) push(e35[k]);

        // Reset state, FIFO already non-empty
        neg();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_stall",   32'(stall_count), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Four-word burst at full rate
        snap();
        start = 1'b1; burst_len = 8'd4;
        neg();
        check("b4_rd_before_t0", 32'(fifo_rd), 32'd0);
        step();
        start = 1'b0;
        neg();
        check("b4_rd_t0p1",    32'(fifo_rd), 32'd1);
        check("b4_valid_t0p1", 32'(m_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            neg();
            check("b4_valid", 32'(m_valid), 32'd1);
            check("b4_data",  32'(m_data),  32'(e35[k]));
        end
        check("b4_drain_no_rd", 32'(fifo_rd), 32'd0);
        step();
        neg();
        check("b4_done",       32'(done),    32'd1);
        check("b4_valid_low",  32'(m_valid), 32'd0);
        step();
        neg();
        check("b4_done_once",  32'(done),    32'd0);
        check("b4_idle",       32'(busy),    32'd0);
        check("b4_fifo_empty", 32'(fifo_empty), 32'd1);
        step();
        check("b4_xfers", 32'(n_xfer - x0), 32'd4);
        check("b4_busy_cycles", 32'(n_busy - b0), 32'd6);

        // Downstream stall for five cycles after the first word
        for (int k = 0; k < 3; k++) push(e36[k]);
        snap();
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        step();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            neg();
            check("st_hold_data",  32'(m_data),  32'(e36[0]));
            check("st_hold_valid", 32'(m_valid), 32'd1);
            check("st_no_rd",      32'(fifo_rd), 32'd0);
            step();
        end
        m_ready = 1'b1;
        wait_idle("st_idle", 20);
        check("st_stall_count", 32'(stall_count), 32'(STALL_EXP));
        check("st_xfers", 32'(n_xfer - x0), 32'd3);
        for (int k = 0; k < 3; k++)
            check("st_order", 32'(xlog[x0 + k]), 32'(e36[k]));
        check("st_done_cnt", 32'(n_done - d0), 32'd1);

        // FIFO runs dry mid-burst, refilled six cycles later
        push(e37[0]); push(e37[1]);
        snap();
        start = 1'b1; burst_len = 8'd4;
        step();
        start = 1'b0;
        repeat (4) step();
        check("dry_valid_low", 32'(m_valid), 32'd0);
        check("dry_busy",      32'(busy),    32'd1);
        check("dry_no_rd",     32'(fifo_rd), 32'd0);
        step();
        push(e37[2]); push(e37[3]);
        wait_idle("dry_idle", 30);
        check("dry_rd_while_empty", 32'(n_viol - v0), 32'd0);
        check("dry_xfers", 32'(n_xfer - x0), 32'd4);
        for (int k = 0; k < 4; k++)
            check("dry_order", 32'(xlog[x0 + k]), 32'(e37[k]));
        check("dry_done_cnt", 32'(n_done - d0), 32'd1);

        // Zero-length request with a word waiting in the FIFO
        push(8'h01);
        snap();
        start = 1'b1; burst_len = 8'd0;
        step();
        start = 1'b0;
        neg();
        check("z_done", 32'(done),    32'd1);
        check("z_busy", 32'(busy),    32'd1);
        check("z_rd",   32'(fifo_rd), 32'd0);
        step();
        neg();
        check("z_done_low", 32'(done), 32'd0);
        check("z_idle",     32'(busy), 32'd0);
        step();
        check("z_busy_cycles", 32'(n_busy - b0), 32'd1);
        check("z_rd_cnt",      32'(n_rd - r0),   32'd0);
        check("z_level",       32'(wp - rp),     32'd1);

        // Maximum-length burst; the waiting 0x01 is its first word
        for (int i = 2; i < 256; i++) push(8'(i));
        snap();
        start = 1'b1; burst_len = 8'd255;
        step();
        start = 1'b0;
        repeat (50) step();
        check("max_mid_busy", 32'(busy), 32'd1);
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        wait_idle("max_idle", 400);
        step();
        check("max_no_restart", 32'(busy), 32'd0);
        check("max_xfers",   32'(n_xfer - x0), 32'd255);
        check("max_rd_cnt",  32'(n_rd - r0),   32'd255);
        check("max_done",    32'(n_done - d0), 32'd1);
        check("max_busy_cycles", 32'(n_busy - b0), 32'd257);
        check("max_level",   32'(wp - rp),     32'd0);
        bad = 0;
        for (int i = 0; i < 255; i++)
            if (xlog[x0 + i] !== 8'(i + 1)) bad = bad + 1;
        check("max_order_errors", 32'(bad), 32'd0);

        // Reset after two of five words popped
        for (int k = 0; k < 5; k++) push(8'hA0 + 8'(k));
        snap();
        start = 1'b1; burst_len = 8'd5;
        step();
        start = 1'b0;
        step();
        step();
        check("rb_level_before", 32'(wp - rp), 32'd3);
        reset = 1'b1;
        #1;
        check("rb_valid", 32'(m_valid), 32'd0);
        check("rb_busy",  32'(busy),    32'd0);
        check("rb_rd",    32'(fifo_rd), 32'd0);
        check("rb_data",  32'(m_data),  32'd0);
        check("rb_stall", 32'(stall_count), 32'd0);
        repeat (3) step();
        check("rb_no_done", 32'(n_done - d0), 32'd0);
        reset = 1'b0;
        step();
        check("rb_idle_after", 32'(busy), 32'd0);
        check("rb_level_after", 32'(wp - rp), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter N, default 8, data word width in bits.
REQ-002 SHALL have parameter L, default 8, burst length and counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-006 SHALL have port burst_len, input, L bits: number of words to read, sampled with start.
REQ-007 SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-008 SHALL have port fifo_rdata, input, N bits: FIFO head word, valid whenever fifo_empty=0 (first-word-fall-through).
REQ-009 SHALL have port fifo_rd, output, 1 bit: FIFO read enable; the FIFO pops its head at the next rising edge.
REQ-010 SHALL have port m_data, output, N bits: downstream data, registered.
REQ-011 SHALL have port m_valid, output, 1 bit: downstream valid, registered.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.
REQ-015 SHALL have port stall_count, output, 16 bits: downstream stall cycle counter (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 with burst_len!=0 SHALL load remaining=burst_len and go to RUN; start=1 with burst_len=0 SHALL go directly to DONE; start=0 SHALL stay in IDLE.
REQ-018 start SHALL be ignored in RUN, DRAIN and DONE; burst_len SHALL not be resampled mid-burst.
REQ-019 Output slot free SHALL be defined as (m_valid=0) or (m_ready=1).
REQ-020 fifo_rd SHALL be combinational, equal to (state=RUN) and (fifo_empty=0) and slot free; it SHALL never be high while fifo_empty=1.
REQ-021 On each cycle with fifo_rd=1: m_data<=fifo_rdata, m_valid<=1, remaining<=remaining-1.
REQ-022 On a cycle with m_valid=1, m_ready=1 and fifo_rd=0, m_valid SHALL go to 0.
REQ-023 While m_valid=1 and m_ready=0, m_data and m_valid SHALL hold unchanged.
REQ-024 RUN SHALL go to DRAIN on the cycle fifo_rd=1 with remaining=1.
REQ-025 DRAIN SHALL go to DONE on the cycle m_valid=1 and m_ready=1; fifo_rd SHALL be 0 in DRAIN.
REQ-026 DONE SHALL assert done=1 for exactly that one cycle and then go to IDLE.
REQ-027 Throughput SHALL be one word per cycle while the FIFO is non-empty and m_ready=1.
REQ-028 Latency: start in IDLE at edge t0 with the FIFO non-empty SHALL give fifo_rd=1 in cycle t0+1 and m_valid=1 in cycle t0+2.
REQ-029 A FIFO running empty mid-burst SHALL stall RUN with no loss or duplication of words; the burst resumes when fifo_empty returns to 0.
REQ-030 remaining SHALL be an L-bit unsigned value; burst_len=2^L-1 SHALL read exactly 2^L-1 words.

Reset
REQ-031 reset=1 SHALL force state=IDLE, remaining=0, m_valid=0, m_data=0, done=0, stall_count=0, and fifo_rd=0 in the same cycle, independent of clk.
REQ-032 reset asserted mid-burst SHALL abandon the burst without a done pulse; words not yet popped SHALL remain in the FIFO.

Configuration
REQ-033 With macro FIFO_READER_STALL_CNT_EN defined, stall_count SHALL increment by 1 on each cycle with m_valid=1 and m_ready=0, saturate at 16'hFFFF, and clear on reset and on each IDLE-to-RUN or IDLE-to-DONE transition.
REQ-034 Without FIFO_READER_STALL_CNT_EN, stall_count SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-035 The bench SHALL cover: FIFO holding 0x11,0x22,0x33,0x44 with m_ready=1, start with burst_len=4 -> m_data 0x11..0x44 on 4 consecutive cycles starting at t0+2, done one cycle after the last transfer, FIFO empty afterwards.
REQ-036 The bench SHALL cover: burst_len=3 with m_ready low for 5 cycles after the first word -> m_data=first word held stable, no fifo_rd during the stall, stall_count=5 with FIFO_READER_STALL_CNT_EN, 0 without it.
REQ-037 The bench SHALL cover: burst_len=4 with the FIFO holding 2 words and 2 more written 6 cycles later -> fifo_rd never high while fifo_empty=1, all 4 words delivered in order, done after the 4th.
REQ-038 The bench SHALL cover: start with burst_len=0 -> no fifo_rd, done pulse 1 cycle later, busy high for exactly 1 cycle.
REQ-039 The bench SHALL cover: reset asserted after 2 of 5 words -> m_valid=0 and busy=0 immediately, no done pulse, 3 words left in the FIFO.
REQ-040 The bench SHALL cover: burst_len=255 with a full-rate source -> exactly 255 transfers, remaining wraps to 0 without underflow, a start pulse during RUN is ignored.
